// File: rtl/activation_sequencer.sv
// Streams signed accumulator elements through a one-stage activation register
// (saturating pass-through or ReLU) for a job of len elements.
module activation_sequencer #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [CNT_WIDTH-1:0]        len,
   input  logic                        mode,
   input  logic signed [IN_WIDTH-1:0]  in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic signed [OUT_WIDTH-1:0] out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        busy,
   output logic                        done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
      {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [IN_WIDTH-1:0] SAT_MIN =
      {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   state_t                       state;
   state_t                       state_nxt;
   logic [CNT_WIDTH-1:0]         len_q;
   logic                         mode_q;
   logic [CNT_WIDTH-1:0]         in_cnt;
   logic [CNT_WIDTH-1:0]         out_cnt;
   logic signed [OUT_WIDTH-1:0]  act_val;
   logic                         in_xfer;
   logic                         out_xfer;
   logic                         last_out_xfer;

   assign busy          = (state == RUN);
   assign in_ready      = (state == RUN) && (in_cnt < len_q) && (!out_valid || out_ready);
   assign in_xfer       = in_valid && in_ready;
   assign out_xfer      = out_valid && out_ready;
   assign last_out_xfer = out_xfer && (out_cnt == len_q - CNT_WIDTH'(1));

   // Upper clamp is common to both modes; ReLU zeroes negatives, pass-through clamps low.
   always_comb begin
      act_val = in_data[OUT_WIDTH-1:0];
      if (in_data > SAT_MAX) begin
         act_val = SAT_MAX[OUT_WIDTH-1:0];
      end else if (mode_q && in_data[IN_WIDTH-1]) begin
         act_val = '0;
      end else if (!mode_q && (in_data < SAT_MIN)) begin
         act_val = SAT_MIN[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start && (len != '0)) state_nxt = RUN;
         RUN:  if (last_out_xfer)        state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q     <= '0;
         mode_q    <= 1'b0;
         in_cnt    <= '0;
         out_cnt   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if ((state == IDLE) && start) begin
            if (len != '0) begin
               len_q   <= len;
               mode_q  <= mode;
               in_cnt  <= '0;
               out_cnt <= '0;
            end else begin
               done <= 1'b1;
            end
         end
         // A load on the same edge as a drain replaces the register with no bubble.
         if (in_xfer) begin
            out_data  <= act_val;
            out_valid <= 1'b1;
            out_last  <= (in_cnt == len_q - CNT_WIDTH'(1));
            in_cnt    <= in_cnt + CNT_WIDTH'(1);
         end else if (out_xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (out_xfer) begin
            out_cnt <= out_cnt + CNT_WIDTH'(1);
         end
         if (last_out_xfer) begin
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_activation_sequencer.sv
// Scoreboard bench for activation_sequencer: stimulus pushes expected outputs,
// a negedge monitor pops and compares on every output transfer.
module tb_activation_sequencer;

   localparam int CW = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [CW-1:0]       len = '0;
   logic                mode = 1'b0;
   logic signed [15:0]  in_data = '0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic signed [7:0]   out_data;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic                out_last;
   logic                busy;
   logic                done;

   typedef struct {int data; bit last;} exp_t;
   exp_t sb[$];
   int   xfer_cyc[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   int   cyc = 0;

   activation_sequencer #(.IN_WIDTH(16), .OUT_WIDTH(8), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .mode(mode),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compares every output transfer against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         xfer_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            check("unexpected_output", int'(out_data), 9999);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", int'(out_data), e.data);
            check("out_last", int'(out_last), int'(e.last));
         end
      end
   end

   task automatic start_job(input int l, input bit m);
      start = 1'b1;
      len   = l[CW-1:0];
      mode  = m;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input int value, input int exp, input bit last);
      exp_t e;
      bit   ok;
      e.data = exp;
      e.last = last;
      sb.push_back(e);
      in_valid = 1'b1;
      in_data  = value[15:0];
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            found = 1'b1;
            break;
         end
      end
      check("done_seen", int'(found), 1);
      check("busy_at_done", int'(busy), 0);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, int'(in_ready), 0);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_out_last"}, int'(out_last), 0);
      check({tag, "_out_data"}, int'(out_data), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // ReLU with saturation, full-rate stream
      xfer_cyc.delete();
      start_job(4, 1'b1);
      send(-5, 0, 1'b0);
      send(0, 0, 1'b0);
      send(100, 100, 1'b0);
      send(300, 127, 1'b1);
      wait_done();
      check("relu_xfer_count", xfer_cyc.size(), 4);
      if (xfer_cyc.size() == 4) check("relu_back_to_back", xfer_cyc[3] - xfer_cyc[0], 3);

      // Saturating pass-through
      start_job(4, 1'b0);
      send(-300, -128, 1'b0);
      send(-128, -128, 1'b0);
      send(127, 127, 1'b0);
      send(200, 127, 1'b1);
      wait_done();

      // Backpressure: output held, input blocked
      start_job(3, 1'b0);
      send(10, 10, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'sd20;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_data", int'(out_data), 10);
         check("stall_valid", int'(out_valid), 1);
         check("stall_last", int'(out_last), 0);
         check("stall_in_ready", int'(in_ready), 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(20, 20, 1'b0);
      send(30, 30, 1'b1);
      wait_done();

      // Zero-length job
      d0 = done_cnt;
      start_job(0, 1'b1);
      @(negedge clk);
      check("len0_done", int'(done), 1);
      check("len0_busy", int'(busy), 0);
      check("len0_valid", int'(out_valid), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("len0_busy_after", int'(busy), 0);
         check("len0_valid_after", int'(out_valid), 0);
      end
      check("len0_done_count", done_cnt - d0, 1);

      // Reset mid-job discards pending output without done
      d0 = done_cnt;
      start_job(5, 1'b0);
      send(1, 1, 1'b0);
      send(2, 2, 1'b0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'sd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pending_before_reset", int'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("abort_hold");
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_sb_empty", sb.size(), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      start_job(2, 1'b1);
      check("restart_busy", int'(busy), 1);
      send(5, 5, 1'b0);
      send(-7, 0, 1'b1);
      wait_done();
      check("restart_done_count", done_cnt - d0, 1);

      // start during RUN is ignored
      d0 = done_cnt;
      start_job(2, 1'b1);
      send(-50, 0, 1'b0);
      start_job(4, 1'b0);
      send(-60, 0, 1'b1);
      wait_done();
      repeat (3) @(negedge clk);
      check("ignored_start_busy", int'(busy), 0);
      check("ignored_start_in_ready", int'(in_ready), 0);
      check("ignored_start_done_count", done_cnt - d0, 1);

      // Maximum length: counters must reach len without wrapping
      start_job(255, 1'b0);
      for (int i = 0; i < 255; i++) send(i - 128, i - 128, i == 254);
      wait_done();

      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/activation_sequencer.md
ACTIVATION_SEQUENCER -- requirements
Module: activation_sequencer

Interface
REQ-001 The module SHALL have parameter IN_WIDTH, default 16, signed input element width.
REQ-002 The module SHALL have parameter OUT_WIDTH, default 8, signed output element width (OUT_WIDTH <= IN_WIDTH).
REQ-003 The module SHALL have parameter CNT_WIDTH, default 16, width of the element-count field.
REQ-004 The module SHALL have port clk input 1: single clock, all state on rising edge.
REQ-005 The module SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-006 The module SHALL have port start input 1: single-cycle pulse that launches a job; sampled only in IDLE.
REQ-007 The module SHALL have port len input CNT_WIDTH: number of elements in the job, sampled with start.
REQ-008 The module SHALL have port mode input 1: 0 = saturating pass-through, 1 = ReLU; sampled with start.
REQ-009 The module SHALL have port in_data input IN_WIDTH: signed element from the accumulator stream.
REQ-010 The module SHALL have ports in_valid input 1 and in_ready output 1: input handshake.
REQ-011 The module SHALL have port out_data output OUT_WIDTH: signed activated element.
REQ-012 The module SHALL have ports out_valid output 1 and out_ready input 1: output handshake.
REQ-013 The module SHALL have port out_last output 1: high with out_valid on the job's final element.
REQ-014 The module SHALL have port busy output 1: high while state is RUN.
REQ-015 The module SHALL have port done output 1: one-cycle pulse at job completion.

Function
REQ-016 The FSM SHALL have states IDLE and RUN.
REQ-017 IDLE with start=1 and len!=0 SHALL latch len and mode, clear both counters, and enter RUN next cycle.
REQ-018 IDLE with start=1 and len==0 SHALL stay IDLE and pulse done the next cycle; no output is produced.
REQ-019 start asserted while in RUN SHALL be ignored, with no effect on len, mode or counters.
REQ-020 in_ready SHALL equal (state==RUN) AND (in_cnt < len_q) AND (out_valid==0 OR out_ready==1).
REQ-021 An input transfer SHALL occur on a cycle with in_valid AND in_ready; it increments in_cnt and loads the output register on the same edge.
REQ-022 Latency SHALL be exactly one cycle: an element accepted at edge N is presented on out_data with out_valid=1 after edge N.
REQ-023 The output register SHALL hold out_data, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-024 An output transfer SHALL occur on out_valid AND out_ready, incrementing out_cnt; if no new input loads on that same edge, out_valid SHALL clear.
REQ-025 Simultaneous output transfer and input transfer on one edge SHALL replace the register contents with no bubble, sustaining one element per cycle.
REQ-026 out_last SHALL be 1 exactly when the registered element is the one with in_cnt index len_q-1.
REQ-027 The output transfer of the last element SHALL return the FSM to IDLE and pulse done on the following cycle, one cycle wide.
REQ-028 In mode 1, negative in_data SHALL produce 0, zero SHALL produce 0, and positive values above 2^(OUT_WIDTH-1)-1 SHALL saturate to 2^(OUT_WIDTH-1)-1.
REQ-029 In mode 0, values SHALL be clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; in-range values pass unchanged.
REQ-030 Counter comparisons SHALL be unsigned; len = 2^CNT_WIDTH-1 SHALL complete without counter wrap.

Reset
REQ-031 While rst_n=0, outputs SHALL be: state IDLE, in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, and counters, len_q and mode_q cleared.
REQ-032 Reset asserted mid-job SHALL abort the job immediately and discard any pending output, with no done pulse.
REQ-033 After rst_n deasserts, the module SHALL accept start on the first rising edge.

Verification
REQ-034 IN_WIDTH=16, OUT_WIDTH=8, mode=1, len=4, inputs -5, 0, 100, 300, out_ready=1 -> outputs 0, 0, 100, 127 on consecutive cycles, out_last on 127, done one cycle later.
REQ-035 Mode=0 with inputs -300, -128, 127, 200 -> outputs -128, -128, 127, 127.
REQ-036 len=3, out_ready held 0 for 5 cycles after the first output -> out_data stable and in_ready=0 throughout; all 3 elements are delivered in order once released.
REQ-037 start with len=0 -> busy stays 0, done pulses once, and out_valid never asserts.
REQ-038 rst_n pulsed low after 2 of 5 elements -> all outputs return to their reset values, no done pulse, and a new start with len=2 completes normally.
REQ-039 start re-pulsed during RUN with a different len/mode -> the current job completes using the original len and mode.
